// File: rtl/edd_pkg.sv
// Shared types and defaults for the theft alarm stage behind the EDD.
package edd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    ALARM,
    HOLD
  } state_t;

  localparam int THEFT_MAX_DEF = 9;

  typedef logic [2:0] upc_t;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v,
    input logic [3:0] max
  );
    return (v >= max) ? max : v + 4'd1;
  endfunction

endpackage

// File: rtl/theft_alarm_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/theft_alarm_ctrl.sv
// Glitch-filtered theft alarm with blinking LED, operator ack
// and a saturating BCD theft counter.
module theft_alarm_ctrl
  import edd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_CYCLES  = 3,
  parameter int THEFT_MAX     = THEFT_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stolen_in,
  input  logic       discount_in,
  input  upc_t       upc,
  input  logic       ack,
  input  logic       clear_count,
  output logic       alarm,
  output logic       blink,
  output logic [3:0] theft_count,
  output upc_t       last_upc,
  output logic       discount_led
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [3:0]    C_MAX  = 4'(THEFT_MAX);

  logic          w_stolen_s;
  logic          w_discount_s;
  logic          w_ack_s;
  logic          w_ack_rise;
  logic          w_enter;
  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_stable_cnt;
  logic [SW-1:0] w_stable_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_ack_q;
  logic [3:0]    r_count;
  upc_t          r_last_upc;

  sync2 u_sync_stolen (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (stolen_in),
    .q      (w_stolen_s)
  );

  sync2 u_sync_discount (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (discount_in),
    .q      (w_discount_s)
  );

  sync2 u_sync_ack (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (ack),
    .q      (w_ack_s)
  );

  assign w_ack_rise = w_ack_s & ~r_ack_q;

  always_comb begin
    w_next       = r_state;
    w_stable_nxt = r_stable_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_stolen_s) begin
          w_next       = ARMING;
          w_stable_nxt = SW'(1);
        end
      end
      ARMING: begin
        if (!w_stolen_s) begin
          w_next       = IDLE;
          w_stable_nxt = '0;
        end else if (r_stable_cnt == S_LAST) begin
          w_next       = ALARM;
          w_stable_nxt = '0;
        end else begin
          w_stable_nxt = r_stable_cnt + SW'(1);
        end
      end
      ALARM: begin
        if (w_ack_rise) w_next = w_stolen_s ? HOLD : IDLE;
      end
      HOLD: begin
        if (!w_stolen_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_enter = (r_state == ARMING) && (w_next == ALARM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_stable_cnt <= '0;
      r_ack_q      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_stable_cnt <= w_stable_nxt;
      r_ack_q      <= w_ack_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_enter) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_state == ALARM && w_next == ALARM) begin
      if (r_blink_cnt == B_LAST) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end else begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end
  end

  // clear wins over a same-edge increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_last_upc <= '0;
    end else begin
      if (clear_count) r_count <= '0;
      else if (w_enter) r_count <= sat_inc(r_count, C_MAX);
      if (w_enter) r_last_upc <= upc;
    end
  end

  assign alarm        = (r_state == ALARM);
  assign blink        = r_blink;
  assign theft_count  = r_count;
  assign last_upc     = r_last_upc;
  assign discount_led = w_discount_s;

endmodule

// File: tb/tb_theft_alarm_ctrl.sv
// Directed bench for theft_alarm_ctrl at default parameters.
module tb_theft_alarm_ctrl;
  import edd_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       stolen_in;
  logic       discount_in;
  upc_t       upc;
  logic       ack;
  logic       clear_count;
  logic       alarm;
  logic       blink;
  logic [3:0] theft_count;
  upc_t       last_upc;
  logic       discount_led;

  int errors = 0;
  int checks = 0;

  theft_alarm_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stolen_in   (stolen_in),
    .discount_in (discount_in),
    .upc         (upc),
    .ack         (ack),
    .clear_count (clear_count),
    .alarm       (alarm),
    .blink       (blink),
    .theft_count (theft_count),
    .last_upc    (last_upc),
    .discount_led(discount_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // full theft: arm, alarm, ack with item gone, settle in IDLE
  task automatic do_theft(input upc_t u);
    upc       = u;
    stolen_in = 1'b1;
    repeat (6) tick();
    ack       = 1'b1;
    stolen_in = 1'b0;
    repeat (3) tick();
    ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    stolen_in   = 1'b1;
    discount_in = 1'b1;
    upc         = 3'b111;
    ack         = 1'b0;
    clear_count = 1'b0;
    repeat (3) tick();
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_alarm got=%0b exp=0", alarm);
    end
    checks++;
    if (blink !== 1'b0) begin
      errors++;
      $display("FAIL reset_blink got=%0b exp=0", blink);
    end
    checks++;
    if (theft_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", theft_count);
    end
    checks++;
    if (last_upc !== 3'd0) begin
      errors++;
      $display("FAIL reset_upc got=%0b exp=0", last_upc);
    end
    checks++;
    if (discount_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_disc got=%0b exp=0", discount_led);
    end
    stolen_in = 1'b0;
    reset_n   = 1'b1;
    tick();
    checks++;
    if (discount_led !== 1'b0) begin
      errors++;
      $display("FAIL disc_edge1 got=%0b exp=0", discount_led);
    end
    tick();
    checks++;
    if (discount_led !== 1'b1) begin
      errors++;
      $display("FAIL disc_edge2 got=%0b exp=1", discount_led);
    end
    discount_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    stolen_in = 1'b1;
    repeat (3) tick();
    stolen_in = 1'b0;
    for (int e = 4; e <= 12; e++) begin
      tick();
      checks++;
      if (alarm !== 1'b0) begin
        errors++;
        $display("FAIL glitch_alarm e=%0d got=%0b exp=0", e, alarm);
      end
    end
    checks++;
    if (theft_count !== 4'd0) begin
      errors++;
      $display("FAIL glitch_count got=%0d exp=0", theft_count);
    end
  endtask

  task automatic test_fire();
    logic ea;
    logic eb;
    upc       = 3'b101;
    stolen_in = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      ea = (e >= 6);
      eb = (e >= 6) ? (((e - 6) / 3) % 2 == 0) : 1'b0;
      checks++;
      if (alarm !== ea) begin
        errors++;
        $display("FAIL fire_alarm e=%0d got=%0b exp=%0b", e, alarm, ea);
      end
      checks++;
      if (blink !== eb) begin
        errors++;
        $display("FAIL fire_blink e=%0d got=%0b exp=%0b", e, blink, eb);
      end
    end
    checks++;
    if (last_upc !== 3'b101) begin
      errors++;
      $display("FAIL fire_upc got=%0b exp=101", last_upc);
    end
    checks++;
    if (theft_count !== 4'd1) begin
      errors++;
      $display("FAIL fire_count got=%0d exp=1", theft_count);
    end
  endtask

  task automatic test_ack_hold();
    ack = 1'b1;
    tick();
    tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL ack_early got=%0b exp=1", alarm);
    end
    tick();
    checks++;
    if (alarm !== 1'b0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear got=%0b%0b exp=00", alarm, blink);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (alarm !== 1'b0) begin
        errors++;
        $display("FAIL hold_refire i=%0d got=%0b exp=0", i, alarm);
      end
    end
    ack       = 1'b0;
    stolen_in = 1'b0;
    repeat (4) tick();
    upc       = 3'b010;
    stolen_in = 1'b1;
    repeat (6) tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL refire_alarm got=%0b exp=1", alarm);
    end
    checks++;
    if (theft_count !== 4'd2 || last_upc !== 3'b010) begin
      errors++;
      $display("FAIL refire_state got=%0d/%0b exp=2/010",
               theft_count, last_upc);
    end
    ack       = 1'b1;
    stolen_in = 1'b0;
    repeat (3) tick();
    ack = 1'b0;
    repeat (4) tick();
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle got=%0b exp=0", alarm);
    end
  endtask

  task automatic test_saturate_clear();
    logic [3:0] ec;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      do_theft(3'(i));
      ec = (i + 1 > 9) ? 4'd9 : 4'(i + 1);
      checks++;
      if (theft_count !== ec) begin
        errors++;
        $display("FAIL sat_count i=%0d got=%0d exp=%0d",
                 i, theft_count, ec);
      end
    end
    upc       = 3'b011;
    stolen_in = 1'b1;
    repeat (5) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL clr_alarm got=%0b exp=1", alarm);
    end
    checks++;
    if (theft_count !== 4'd0) begin
      errors++;
      $display("FAIL clr_count got=%0d exp=0", theft_count);
    end
    checks++;
    if (last_upc !== 3'b011) begin
      errors++;
      $display("FAIL clr_upc got=%0b exp=011", last_upc);
    end
    ack       = 1'b1;
    stolen_in = 1'b0;
    repeat (3) tick();
    ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    upc       = 3'b110;
    stolen_in = 1'b1;
    repeat (6) tick();
    checks++;
    if (alarm !== 1'b1 || blink !== 1'b1 || theft_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_pre got=%0b%0b/%0d exp=11/1",
               alarm, blink, theft_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (alarm !== 1'b0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got=%0b%0b exp=00", alarm, blink);
    end
    checks++;
    if (theft_count !== 4'd0 || last_upc !== 3'd0) begin
      errors++;
      $display("FAIL mid_count got=%0d/%0b exp=0/0",
               theft_count, last_upc);
    end
    stolen_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_fire();
    test_ack_hold();
    test_saturate_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
